// File: rtl/floor_sched_pkg.sv
// rtl/floor_sched_pkg.sv - shared types and constants for the floor request scheduler
// Contents: direction FSM state enum, encoder search modes, direction
// constants and floor-letter names for the 4-floor build.
package floor_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  typedef enum logic {
    LOW_FIRST  = 1'b0,
    HIGH_FIRST = 1'b1
  } enc_mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [1:0] FLOOR_A = 2'd0;
  localparam logic [1:0] FLOOR_B = 2'd1;
  localparam logic [1:0] FLOOR_C = 2'd2;
  localparam logic [1:0] FLOOR_D = 2'd3;

endpackage

// File: rtl/floor_request_scheduler_if.sv
// rtl/floor_request_scheduler_if.sv - request/target bundle between call logic, scheduler and car controller
// Ports (master = request/car side, slave = scheduler):
//   req_in, cur_floor, served  : master -> slave
//   valid, target, dir_up, pending : slave -> master
interface floor_request_scheduler_if #(
  parameter int NUM_FLOORS = 4
);
  localparam int FLOOR_W = $clog2(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] req_in;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  served;
  logic                  valid;
  logic [FLOOR_W-1:0]    target;
  logic                  dir_up;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output req_in, cur_floor, served,
    input  valid, target, dir_up, pending
  );

  modport slave (
    input  req_in, cur_floor, served,
    output valid, target, dir_up, pending
  );

endinterface

// File: rtl/masked_priority_encoder.sv
// rtl/masked_priority_encoder.sv - combinational priority encoder over (bitmap & mask)
// Ports:
//   bitmap : candidate bits
//   mask   : bits allowed to participate
//   valid  : at least one unmasked bit set
//   index  : lowest (LOW_FIRST) or highest (HIGH_FIRST) set unmasked bit, 0 when none
module masked_priority_encoder
  import floor_sched_pkg::*;
#(
  parameter int        WIDTH = 4,
  parameter enc_mode_e MODE  = LOW_FIRST,
  localparam int       IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] bitmap,
  input  logic [WIDTH-1:0] mask,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [WIDTH-1:0] masked;

  always_comb begin
    masked = bitmap & mask;
    valid  = |masked;
    index  = '0;
    // Scan toward the preferred end so the last hit is the winner.
    if (MODE == LOW_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (masked[i]) index = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (masked[i]) index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/floor_request_scheduler.sv
// rtl/floor_request_scheduler.sv - SCAN-order floor call scheduler with pending bitmap
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus (slave): req_in/cur_floor/served in; valid/target/dir_up/pending out
module floor_request_scheduler
  import floor_sched_pkg::*;
#(
  parameter int NUM_FLOORS = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  floor_request_scheduler_if.slave           bus
);

  localparam int FLOOR_W = $clog2(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic                  dir_up_q, dir_up_d;

  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] above_mask, below_mask;
  logic                  any_above, any_below, any_pending;
  logic [FLOOR_W-1:0]    up_idx, down_idx;

  // Pending bitmap: set wins over clear, so a call re-pressed at the
  // floor being served stays registered.
  always_comb begin
    clr = '0;
    if (bus.served && valid_q) clr = NUM_FLOORS'(1) << target_q;
    pending_d = (pending_q & ~clr) | bus.req_in;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = (FLOOR_W'(i) >= bus.cur_floor);
      below_mask[i] = (FLOOR_W'(i) <= bus.cur_floor);
    end
    any_pending = |pending_d;
  end

  masked_priority_encoder #(
    .WIDTH (NUM_FLOORS),
    .MODE  (LOW_FIRST)
  ) u_up_enc (
    .bitmap (pending_d),
    .mask   (above_mask),
    .valid  (any_above),
    .index  (up_idx)
  );

  masked_priority_encoder #(
    .WIDTH (NUM_FLOORS),
    .MODE  (HIGH_FIRST)
  ) u_down_enc (
    .bitmap (pending_d),
    .mask   (below_mask),
    .valid  (any_below),
    .index  (down_idx)
  );

  // Next-state and registered outputs. Entering UP from DOWN only happens
  // when nothing is at/below the car, so the upward search always hits.
  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    target_d = target_q;
    dir_up_d = dir_up_q;

    case (state_q)
      IDLE: begin
        if (!any_pending)   state_d = IDLE;
        else if (any_above) state_d = UP;
        else                state_d = DOWN;
      end
      UP: begin
        if (any_above)        state_d = UP;
        else if (any_pending) state_d = DOWN;
        else                  state_d = IDLE;
      end
      DOWN: begin
        if (any_below)        state_d = DOWN;
        else if (any_pending) state_d = UP;
        else                  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      UP: begin
        valid_d  = 1'b1;
        target_d = up_idx;
        dir_up_d = DIR_UP;
      end
      DOWN: begin
        valid_d  = 1'b1;
        target_d = down_idx;
        dir_up_d = DIR_DOWN;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      target_q  <= '0;
      dir_up_q  <= DIR_UP;
    end else begin
      pending_q <= pending_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      target_q  <= target_d;
      dir_up_q  <= dir_up_d;
    end
  end

  assign bus.pending = pending_q;
  assign bus.valid   = valid_q;
  assign bus.target  = target_q;
  assign bus.dir_up  = dir_up_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb/tb_floor_request_scheduler.sv - self-checking bench for floor_request_scheduler (4- and 8-floor builds)
module tb_floor_request_scheduler;
  import floor_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n4 = 1'b0;
  logic rst_n8 = 1'b0;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  floor_request_scheduler_if #(.NUM_FLOORS(4)) if4 ();
  floor_request_scheduler_if #(.NUM_FLOORS(8)) if8 ();

  floor_request_scheduler #(.NUM_FLOORS(4)) dut4 (.clk(clk), .rst_n(rst_n4), .bus(if4));
  floor_request_scheduler #(.NUM_FLOORS(8)) dut8 (.clk(clk), .rst_n(rst_n8), .bus(if8));

  // Model: st 0 = idle, 1 = up, 2 = down
  typedef struct {
    logic [63:0] pend;
    int          st;
    bit          valid;
    int          target;
    bit          dir_up;
  } model_t;

  localparam model_t M_RESET = '{64'd0, 0, 1'b0, 0, 1'b1};

  model_t m4 = M_RESET;
  model_t m8 = M_RESET;

  function automatic model_t step(input int n, input logic [63:0] req, input int cur,
                                  input bit srv, input model_t m);
    model_t r;
    logic [63:0] pn;
    bit above, below;
    int lo, hi, ns;
    r = m;
    pn = m.pend;
    if (srv && m.valid) pn[m.target] = 1'b0;
    pn = pn | req;
    above = 0; below = 0; lo = -1; hi = -1;
    for (int i = 0; i < n; i++) begin
      if (pn[i]) begin
        if (i >= cur) begin above = 1; if (lo < 0) lo = i; end
        if (i <= cur) begin below = 1; hi = i; end
      end
    end
    ns = m.st;
    if (pn == 64'd0) ns = 0;
    else if (m.st == 0) ns = above ? 1 : 2;
    else if (m.st == 1) ns = above ? 1 : 2;
    else ns = below ? 2 : 1;
    r.pend = pn;
    r.st = ns;
    r.valid = (ns != 0);
    if (ns == 1) begin r.target = lo; r.dir_up = 1'b1; end
    if (ns == 2) begin r.target = hi; r.dir_up = 1'b0; end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n4) begin
    if (!rst_n4) m4 <= M_RESET;
    else m4 <= step(4, 64'(if4.req_in), int'(if4.cur_floor), if4.served, m4);
  end

  always @(posedge clk or negedge rst_n8) begin
    if (!rst_n8) m8 <= M_RESET;
    else m8 <= step(8, 64'(if8.req_in), int'(if8.cur_floor), if8.served, m8);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m4_pending", 64'(if4.pending), m4.pend);
      chk("m4_valid", 64'(if4.valid), 64'(m4.valid));
      chk("m4_target", 64'(if4.target), 64'(m4.target));
      chk("m4_dir_up", 64'(if4.dir_up), 64'(m4.dir_up));
      if (if4.valid === 1'b1) chk("inv4_target_pending", 64'(if4.pending[if4.target]), 64'd1);
      chk("m8_pending", 64'(if8.pending), m8.pend);
      chk("m8_valid", 64'(if8.valid), 64'(m8.valid));
      chk("m8_target", 64'(if8.target), 64'(m8.target));
      chk("m8_dir_up", 64'(if8.dir_up), 64'(m8.dir_up));
      if (if8.valid === 1'b1) chk("inv8_target_pending", 64'(if8.pending[if8.target]), 64'd1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic out4(input string name, input logic [3:0] p, input logic v,
                      input logic [1:0] t, input logic d);
    chk({name, "_pending"}, 64'(if4.pending), 64'(p));
    chk({name, "_valid"}, 64'(if4.valid), 64'(v));
    chk({name, "_target"}, 64'(if4.target), 64'(t));
    chk({name, "_dir_up"}, 64'(if4.dir_up), 64'(d));
  endtask

  task automatic out8(input string name, input logic [7:0] p, input logic v,
                      input logic [2:0] t, input logic d);
    chk({name, "_pending"}, 64'(if8.pending), 64'(p));
    chk({name, "_valid"}, 64'(if8.valid), 64'(v));
    chk({name, "_target"}, 64'(if8.target), 64'(t));
    chk({name, "_dir_up"}, 64'(if8.dir_up), 64'(d));
  endtask

  initial begin
    if4.req_in = 4'b1111; if4.cur_floor = 2'd0; if4.served = 1'b0;
    if8.req_in = 8'd0;    if8.cur_floor = 3'd0; if8.served = 1'b0;
    repeat (2) cyc();
    chk_en = 1'b1;
    out4("reset_held", 4'b0000, 1'b0, 2'd0, 1'b1);
    out8("reset8", 8'd0, 1'b0, 3'd0, 1'b1);

    rst_n4 = 1'b1; rst_n8 = 1'b1;
    cyc();
    chk("release_pending", 64'(if4.pending), 64'hF);
    if4.req_in = 4'b0000;
    rst_n4 = 1'b0; cyc(); rst_n4 = 1'b1; cyc();

    // Single call above the car, then serve it
    if4.cur_floor = 2'd1; if4.req_in = 4'b1000; cyc(); if4.req_in = 4'b0000;
    out4("single_call", 4'b1000, 1'b1, FLOOR_D, 1'b1);
    if4.served = 1'b1; cyc(); if4.served = 1'b0;
    out4("single_served", 4'b0000, 1'b0, FLOOR_D, 1'b1);
    if4.served = 1'b1; cyc(); if4.served = 1'b0;
    out4("served_idle_ignored", 4'b0000, 1'b0, FLOOR_D, 1'b1);

    // Two calls, serve top then reverse
    if4.cur_floor = 2'd2; if4.req_in = 4'b1001; cyc(); if4.req_in = 4'b0000;
    out4("two_calls", 4'b1001, 1'b1, FLOOR_D, 1'b1);
    if4.cur_floor = 2'd3; if4.served = 1'b1; cyc(); if4.served = 1'b0;
    out4("reverse", 4'b0001, 1'b1, FLOOR_A, 1'b0);
    if4.cur_floor = 2'd0; if4.served = 1'b1; cyc(); if4.served = 1'b0;
    out4("idle_dir_hold", 4'b0000, 1'b0, FLOOR_A, 1'b0);

    // Preemption by a call between car and target
    if4.cur_floor = 2'd0; if4.req_in = 4'b1000; cyc(); if4.req_in = 4'b0000;
    out4("pre_start", 4'b1000, 1'b1, FLOOR_D, 1'b1);
    if4.cur_floor = 2'd1; if4.req_in = 4'b0100; cyc(); if4.req_in = 4'b0000;
    out4("preempt", 4'b1100, 1'b1, FLOOR_C, 1'b1);
    if4.cur_floor = 2'd2; if4.served = 1'b1; cyc(); if4.served = 1'b0;
    out4("after_preempt", 4'b1000, 1'b1, FLOOR_D, 1'b1);
    if4.cur_floor = 2'd3; if4.served = 1'b1; cyc(); if4.served = 1'b0;
    out4("pre_done", 4'b0000, 1'b0, FLOOR_D, 1'b1);

    // Same-cycle serve and re-request of the target floor
    if4.cur_floor = 2'd2; if4.req_in = 4'b0100; cyc();
    out4("set_target2", 4'b0100, 1'b1, FLOOR_C, 1'b1);
    if4.served = 1'b1; cyc(); if4.served = 1'b0; if4.req_in = 4'b0000;
    out4("set_wins", 4'b0100, 1'b1, FLOOR_C, 1'b1);
    if4.served = 1'b1; cyc(); if4.served = 1'b0;
    out4("set_wins_clear", 4'b0000, 1'b0, FLOOR_C, 1'b1);

    // 8-floor build: 6, 7, then reverse to 0
    if8.cur_floor = 3'd5; if8.req_in = 8'b1100_0001; cyc(); if8.req_in = 8'd0;
    out8("f8_t6", 8'b1100_0001, 1'b1, 3'd6, 1'b1);
    if8.cur_floor = 3'd6; if8.served = 1'b1; cyc(); if8.served = 1'b0;
    out8("f8_t7", 8'b1000_0001, 1'b1, 3'd7, 1'b1);
    if8.cur_floor = 3'd7; if8.served = 1'b1; cyc(); if8.served = 1'b0;
    out8("f8_t0", 8'b0000_0001, 1'b1, 3'd0, 1'b0);
    if8.req_in = 8'b1100_0000; cyc(); if8.req_in = 8'd0;
    out8("f8_at_car", 8'b1100_0001, 1'b1, 3'd7, 1'b0);

    // Asynchronous reset between clock edges
    #2 rst_n8 = 1'b0;
    #1 out8("f8_async_reset", 8'd0, 1'b0, 3'd0, 1'b1);
    cyc();
    rst_n8 = 1'b1;
    cyc();
    out8("f8_after_reset", 8'd0, 1'b0, 3'd0, 1'b1);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
